// File: rtl/func5_pkg.sv
// Shared definitions for the 5-input minterm sweep checker.
// Holds the vector/count widths, the golden ON and don't-care sets
// (bit i = minterm i, i = {X,Y,Z,K,M} with X as MSB), and the sequencer
// state encoding.
package func5_pkg;

    localparam int unsigned VEC_W = 5;
    localparam int unsigned NVEC  = 32;
    localparam int unsigned ERR_W = 6;

    // Golden ON-set and don't-care set (minterms 0,5,8,9,19,20,23,24).
    localparam logic [NVEC-1:0] ON_MASK = 32'h0A26_8C5C;
    localparam logic [NVEC-1:0] DC_MASK = 32'h0198_0321;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/func5_sweep_ctrl_if.sv
// Board-side bundle of the sweep controller.
//   start, hold : sweep control from the board
//   drv_vec     : {X,Y,Z,K,M} driven to the function under test
//   obs         : function outputs, obs[0]=S_OR2, obs[1]=S_OR4, obs[2]=S_OR5
//   busy, done  : sweep status
//   tt0..tt2    : captured truth tables, err0..err2 : mismatch counts
//   pass        : done with all three mismatch counts at zero
// slave is the controller side, master the board/function side.
interface func5_sweep_ctrl_if;
    import func5_pkg::*;

    logic             start;
    logic             hold;
    logic [VEC_W-1:0] drv_vec;
    logic [2:0]       obs;
    logic             busy;
    logic             done;
    logic [NVEC-1:0]  tt0;
    logic [NVEC-1:0]  tt1;
    logic [NVEC-1:0]  tt2;
    logic [ERR_W-1:0] err0;
    logic [ERR_W-1:0] err1;
    logic [ERR_W-1:0] err2;
    logic             pass;

    modport slave (
        input  start, hold, obs,
        output drv_vec, busy, done, tt0, tt1, tt2, err0, err1, err2, pass
    );

    modport master (
        output start, hold, obs,
        input  drv_vec, busy, done, tt0, tt1, tt2, err0, err1, err2, pass
    );

endinterface

// File: rtl/func5_chk_lane.sv
// One checker lane: records the observed output of one minimisation
// variant into a 32-bit truth table and counts care-point mismatches
// against the golden ON set.
//   clk, rst : clock, synchronous active-high reset
//   clr      : clear table and count (sweep launch)
//   cap      : capture obs_bit into bit idx this cycle
//   idx      : current input vector
//   obs_bit  : observed function output
//   gold_bit : golden ON-set bit for idx
//   dc_bit   : don't-care bit for idx
//   tt, err  : truth table and mismatch count
//   hit_c    : mismatch being counted this cycle (combinational)
module func5_chk_lane
    import func5_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             cap,
    input  logic [VEC_W-1:0] idx,
    input  logic             obs_bit,
    input  logic             gold_bit,
    input  logic             dc_bit,
    output logic [NVEC-1:0]  tt,
    output logic [ERR_W-1:0] err,
    output logic             hit_c
);

    // Don't-care points never count; at most 32 hits so err cannot wrap.
    assign hit_c = cap & (obs_bit ^ gold_bit) & ~dc_bit;

    // Truth-table capture and mismatch counter.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            tt  <= '0;
            err <= '0;
        end else if (cap) begin
            tt[idx] <= obs_bit;
            err     <= err + ERR_W'(hit_c);
        end
    end

endmodule

// File: rtl/func5_sweep_ctrl.sv
// Exhaustive sweep sequencer for the 5-input minterm function.
// Drives all 32 vectors in order, holds each for SETTLE cycles, then
// samples the three candidate outputs into per-lane truth tables and
// mismatch counters. Reports pass when all three lanes are clean.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : slave side of func5_sweep_ctrl_if (start, hold, obs in;
//          drv_vec, busy, done, tt0..2, err0..2, pass out)
// SETTLE: cycles each vector is held before sampling, legal 1..15.
module func5_sweep_ctrl
    import func5_pkg::*;
#(
    parameter int unsigned SETTLE = 1
)
(
    input  logic               clk,
    input  logic               rst,
    func5_sweep_ctrl_if.slave  bus
);

    localparam int unsigned   SCNT_W      = 4;
    localparam logic [SCNT_W-1:0] SCNT_RELOAD = SCNT_W'(SETTLE - 1);

    state_t            state;
    logic [VEC_W-1:0]  idx;
    logic [SCNT_W-1:0] scnt;

    logic       launch_c;
    logic       cap_c;
    logic       last_c;
    logic       clean_c;
    logic [2:0] hit_c;

    // start only counts when not already sweeping.
    assign launch_c = bus.start & ((state == ST_IDLE) | (state == ST_DONE));
    assign cap_c    = (state == ST_SETTLE) & ~bus.hold & (scnt == '0);
    assign last_c   = (idx == VEC_W'(NVEC - 1));

    // Includes the final capture so pass is valid on the same edge as done.
    assign clean_c  = (bus.err0 == '0) & (bus.err1 == '0) & (bus.err2 == '0)
                    & (hit_c == '0);

    func5_chk_lane u_lane0 (
        .clk      (clk),
        .rst      (rst),
        .clr      (launch_c),
        .cap      (cap_c),
        .idx      (idx),
        .obs_bit  (bus.obs[0]),
        .gold_bit (ON_MASK[idx]),
        .dc_bit   (DC_MASK[idx]),
        .tt       (bus.tt0),
        .err      (bus.err0),
        .hit_c    (hit_c[0])
    );

    func5_chk_lane u_lane1 (
        .clk      (clk),
        .rst      (rst),
        .clr      (launch_c),
        .cap      (cap_c),
        .idx      (idx),
        .obs_bit  (bus.obs[1]),
        .gold_bit (ON_MASK[idx]),
        .dc_bit   (DC_MASK[idx]),
        .tt       (bus.tt1),
        .err      (bus.err1),
        .hit_c    (hit_c[1])
    );

    func5_chk_lane u_lane2 (
        .clk      (clk),
        .rst      (rst),
        .clr      (launch_c),
        .cap      (cap_c),
        .idx      (idx),
        .obs_bit  (bus.obs[2]),
        .gold_bit (ON_MASK[idx]),
        .dc_bit   (DC_MASK[idx]),
        .tt       (bus.tt2),
        .err      (bus.err2),
        .hit_c    (hit_c[2])
    );

    // Sequencer: vector index, settle countdown and registered status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            scnt        <= '0;
            bus.drv_vec <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.pass    <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (launch_c) begin
                        state       <= ST_SETTLE;
                        idx         <= '0;
                        scnt        <= SCNT_RELOAD;
                        bus.drv_vec <= '0;
                        bus.busy    <= 1'b1;
                        bus.done    <= 1'b0;
                        bus.pass    <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (!bus.hold) begin
                        if (scnt != '0) begin
                            scnt <= scnt - 1'b1;
                        end else if (last_c) begin
                            state       <= ST_DONE;
                            bus.drv_vec <= '0;
                            bus.busy    <= 1'b0;
                            bus.done    <= 1'b1;
                            bus.pass    <= clean_c;
                        end else begin
                            idx         <= idx + 1'b1;
                            bus.drv_vec <= idx + 1'b1;
                            scnt        <= SCNT_RELOAD;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/func5_sweep_ctrl.md
Name: func5_sweep_ctrl

Overview:
- Sequencer that exhaustively drives the 5-input minterm logic (inputs X,Y,Z,K,M; three candidate outputs: plain SOP, SOP without don't-cares, SOP with selected don't-cares).
- Steps through all 32 input vectors, samples each candidate output, and builds a 32-bit truth table per candidate.
- Counts mismatches per candidate against the golden ON/DC sets and reports pass/fail.
- Sits between board start/reset controls and the combinational function instance. Used for on-board self-check of each minimisation variant.

Parameters:
- SETTLE, 1, cycles each vector is held before sampling (legal 1..15).
- ON_MASK, 32'h0A26_8C5C, golden ON-set (bit i = minterm i, i = {X,Y,Z,K,M}, X MSB).
- DC_MASK, 32'h0198_0321, don't-care set (minterms 0,5,8,9,19,20,23,24).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  pulse: begin sweep (accepted in IDLE or DONE only)
- hold  in  1  freeze sweep while high (SETTLE state only)
- drv_vec  out  5  {X,Y,Z,K,M} driven to the function; registered
- obs  in  3  sampled outputs: obs[0]=S_OR2, obs[1]=S_OR4, obs[2]=S_OR5
- busy  out  1  high in SETTLE
- done  out  1  high in DONE
- tt0, tt1, tt2  out  32 each  captured truth tables, bit i = obs at vector i
- err0, err1, err2  out  6 each  mismatch counts, range 0..32
- pass  out  1  done & (err0==0) & (err1==0) & (err2==0)

Behaviour:
- Single clock domain. One synchronous, active-high reset.
- Reset, whether idle or mid-sweep, forces on the next edge:
  - state=IDLE; drv_vec=0; all tt and err outputs=0; busy=done=pass=0.
- FSM states: IDLE, SETTLE, DONE.
- IDLE:
  - drv_vec=0.
  - start=1 → clear tt/err, idx=0, scnt=SETTLE-1, go to SETTLE.
- SETTLE:
  - drv_vec=idx.
  - hold=1 → idx, scnt and results frozen.
  - Else, scnt!=0 → scnt decrements.
  - Else (scnt==0) → capture obs into bit idx of each tt, and update each errN.
    - If idx==31 → go to DONE.
    - Else idx+1, scnt reloads to SETTLE-1.
  - start is ignored while in SETTLE.
- Mismatch rule, lane n at vector i: errN increments when (obs[n] ^ ON_MASK[i]) & ~DC_MASK[i].
  - errN is 6 bits wide and cannot wrap (max value 32).
- DONE:
  - done=1; drv_vec=0; results held.
  - start=1 → clear and restart exactly as from IDLE. done drops on that edge.
- Timing with no hold, start sampled at edge 0:
  - Vector i is driven from cycle i*SETTLE+1.
  - Captured at edge (i+1)*SETTLE.
  - done rises at cycle 32*SETTLE+1.
- obs is treated as combinational from drv_vec: sampled SETTLE cycles after drv_vec changes.
- hold asserted in IDLE or DONE has no effect.

Decomposition:
- Shared package func5_pkg holds:
  - state enum {IDLE, SETTLE, DONE}
  - golden ON_MASK / DC_MASK constants
  - VEC_W=5, NVEC=32, ERR_W=6
- Sub-module func5_chk_lane, instantiated three times:
  - Inputs: clk, rst, clr, cap, idx, obs bit, golden bit, dc bit.
  - Holds that lane's 32-bit truth table and 6-bit error counter.
  - Top level keeps the FSM, idx and settle counter.

Test Plan:
- Golden sweep, SETTLE=1, obs wired to a real function model. Expected after start:
  - done at cycle 33
  - tt0=tt2=32'h0AAE_8D5D, tt1=32'h0A26_8C5C
  - err0=err1=err2=0, pass=1
- Fault injection, obs[2] stuck at 1: err2=12 (the care-OFF points), err0=err1=0, pass=0, tt2=32'hFFFF_FFFF.
- Hold, SETTLE=1: hold high for 5 cycles while drv_vec=10. Expected:
  - drv_vec stays 10 for the whole hold
  - done at cycle 38
  - results identical to the golden sweep
- Reset mid-sweep: assert rst while drv_vec=17. Expected:
  - next cycle: IDLE, all outputs 0
  - a fresh start completes the golden result
- SETTLE=3, with a start pulse issued mid-sweep. Expected:
  - the mid-sweep start is ignored
  - done at cycle 97
  - a start in DONE clears err/tt within 1 cycle, drops done, and re-runs to an identical result
